// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

  // Control states: waiting for operands, stepping digits, presenting the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple chain of full-adder cells. Also exposes the
// carry into the top bit so the caller can derive two's-complement overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  // Ripple the carry through one full-adder cell per bit
  always_comb begin
    logic c;
    c    = cin;
    sum  = '0;
    cmsb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor working DIGIT bits per clock, with
// ready/valid handshakes on operands and result, and carry/overflow/zero flags.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int SW    = $clog2(STEPS + 1);

  state_t           state, state_next;
  logic [SW-1:0]    step;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             accept, last;
  logic [DIGIT-1:0] da, db, ds;
  logic             dcout, dcmsb;
  logic [WIDTH-1:0] sum_next;

  assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (step == SW'(STEPS - 1));

  // Pick the operand digits addressed by the step counter
  always_comb begin
    da = '0;
    db = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (step == SW'(i)) begin
        da = a_reg[i*DIGIT +: DIGIT];
        db = b_reg[i*DIGIT +: DIGIT];
      end
    end
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a   (da),
    .b   (db),
    .cin (carry),
    .sum (ds),
    .cout(dcout),
    .cmsb(dcmsb)
  );

  // Result with the current digit merged in; used for writeback and the zero flag
  always_comb begin
    sum_next = sum;
    for (int i = 0; i < STEPS; i++) begin
      if (step == SW'(i)) sum_next[i*DIGIT +: DIGIT] = ds;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; a HOLD that is consumed can take a new bundle straight into RUN
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last)     state_next = HOLD;
      HOLD:    if (out_ready) state_next = in_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one digit per cycle into sum and the carry register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step     <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + ~cin, so borrow-in becomes an inverted carry-in
      a_reg <= a;
      b_reg <= (mode == MODE_SUB) ? ~b : b;
      carry <= (mode == MODE_SUB) ? ~cin : cin;
      step  <= '0;
    end else if (state == RUN) begin
      sum   <= sum_next;
      carry <= dcout;
      step  <= step + SW'(1);
      if (last) begin
        cout     <= dcout;
        overflow <= dcmsb ^ dcout;
        zero     <= (sum_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench: unit 0 is WIDTH=16/DIGIT=4, unit 1 is WIDTH=16/DIGIT=16.
module tb_digit_serial_addsub;
  import addsub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid[2], in_ready[2], mode[2], cin[2];
  logic        out_valid[2], out_ready[2], cout[2], overflow[2], zero[2];
  logic [15:0] a[2], b[2], sum[2];

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t q0[$], q1[$];
  res_t e0, e1;
  int   checks = 0;
  int   errors = 0;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .mode(mode[0]), .a(a[0]), .b(b[0]), .cin(cin[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum[0]), .cout(cout[0]), .overflow(overflow[0]),
    .zero(zero[0])
  );

  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .mode(mode[1]), .a(a[1]), .b(b[1]), .cin(cin[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum[1]), .cout(cout[1]), .overflow(overflow[1]),
    .zero(zero[1])
  );

  function automatic res_t mk(logic [15:0] s, logic c, logic o, logic z);
    res_t r;
    r.sum = s; r.cout = c; r.ovf = o; r.zero = z;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare whenever a result is consumed
  always @(negedge clk) begin
    if (reset_n && out_valid[0] && out_ready[0]) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result_a: got sum %0h with empty scoreboard", sum[0]);
      end else begin
        e0 = q0.pop_front();
        check("sum_a", 32'(sum[0]), 32'(e0.sum));
        check("cout_a", 32'(cout[0]), 32'(e0.cout));
        check("overflow_a", 32'(overflow[0]), 32'(e0.ovf));
        check("zero_a", 32'(zero[0]), 32'(e0.zero));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_valid[1] && out_ready[1]) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result_b: got sum %0h with empty scoreboard", sum[1]);
      end else begin
        e1 = q1.pop_front();
        check("sum_b", 32'(sum[1]), 32'(e1.sum));
        check("cout_b", 32'(cout[1]), 32'(e1.cout));
        check("overflow_b", 32'(overflow[1]), 32'(e1.ovf));
        check("zero_b", 32'(zero[1]), 32'(e1.zero));
      end
    end
  end

  // Present a bundle until accepted; returns the number of edges it took
  task automatic send(input int u, input logic [15:0] av, input logic [15:0] bv,
                      input logic m, input logic c, input res_t e, output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    a[u] = av; b[u] = bv; mode[u] = m; cin[u] = c; in_valid[u] = 1'b1;
    while (!acc && tries < 40) begin
      @(negedge clk);
      acc = in_ready[u];
      tick();
      tries++;
    end
    check("accept", 32'(acc), 32'd1);
    if (acc) begin
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    // Scramble inputs after the accept edge; the result must not follow them
    in_valid[u] = 1'b0;
    a[u] = ~av; b[u] = ~bv; mode[u] = ~m; cin[u] = ~c;
  endtask

  task automatic wait_valid(input int u, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid[u] && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
  endtask

  int t;
  int n;

  initial begin
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; mode[u] = 1'b0; cin[u] = 1'b0;
      a[u] = '0; b[u] = '0; out_ready[u] = 1'b1;
    end
    #3;
    for (int u = 0; u < 2; u++) begin
      check("rst_sum", 32'(sum[u]), 32'd0);
      check("rst_flags", {29'd0, cout[u], overflow[u], zero[u]}, 32'd0);
      check("rst_out_valid", 32'(out_valid[u]), 32'd0);
      check("rst_in_ready", 32'(in_ready[u]), 32'd1);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Carry out of the top with a zero result
    send(0, 16'hFFFF, 16'h0001, MODE_ADD, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1), t);
    wait_valid(0, 4);
    tick();

    // Subtract with signed overflow, then a back-to-back negative result
    send(0, 16'h8000, 16'h0001, MODE_SUB, 1'b0, mk(16'h7FFF, 1'b1, 1'b1, 1'b0), t);
    wait_valid(0, 4);
    send(0, 16'h0003, 16'h0005, MODE_SUB, 1'b0, mk(16'hFFFE, 1'b0, 1'b0, 1'b0), t);
    wait_valid(0, 4);
    tick();

    // Backpressure: result frozen while out_ready is low
    out_ready[0] = 1'b0;
    send(0, 16'h1234, 16'h4321, MODE_ADD, 1'b1, mk(16'h5556, 1'b0, 1'b0, 1'b0), t);
    wait_valid(0, 4);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(out_valid[0]), 32'd1);
      check("hold_in_ready", 32'(in_ready[0]), 32'd0);
      check("hold_sum", 32'(sum[0]), 32'h5556);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    check("consumed", 32'(out_valid[0]), 32'd0);

    // Back-to-back: second bundle accepted on the consume edge
    send(0, 16'h1111, 16'h2222, MODE_ADD, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0), t);
    wait_valid(0, 4);
    send(0, 16'h0001, 16'h0001, MODE_ADD, 1'b0, mk(16'h0002, 1'b0, 1'b0, 1'b0), t);
    check("b2b_tries", 32'(t), 32'd1);
    check("b2b_in_run", {30'd0, out_valid[0], in_ready[0]}, 32'd0);
    wait_valid(0, 4);
    tick();

    // Reset after two RUN edges aborts the operation
    send(0, 16'hAAAA, 16'h1111, MODE_ADD, 1'b0, mk(16'hBBBB, 1'b0, 1'b0, 1'b0), t);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    if (q0.size() > 0) void'(q0.pop_back());
    check("abort_sum", 32'(sum[0]), 32'd0);
    check("abort_flags", {29'd0, cout[0], overflow[0], zero[0]}, 32'd0);
    check("abort_out_valid", 32'(out_valid[0]), 32'd0);
    check("abort_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid[0]) n++;
    end
    check("abort_no_valid", 32'(n), 32'd0);
    send(0, 16'h00FF, 16'h0001, MODE_ADD, 1'b0, mk(16'h0100, 1'b0, 1'b0, 1'b0), t);
    wait_valid(0, 4);

    // Full-width digit: registered adder with a single RUN cycle
    send(1, 16'h7FFF, 16'h0001, MODE_ADD, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0), t);
    wait_valid(1, 1);
    tick();
    send(1, 16'h0000, 16'h0000, MODE_SUB, 1'b1, mk(16'hFFFF, 1'b0, 1'b0, 1'b0), t);
    wait_valid(1, 1);

    // Let the monitors drain the scoreboards
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check("drain_a", 32'(q0.size()), 32'd0);
    check("drain_b", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
